sa_share_ctrl: RTL and testbench

//   Round-robin scheduler that shares one sequential 8-bit arithmetic unit (start/done

---
 rtl/sa_share_ctrl.sv | 146 ++++++++++++++
 tb/tb_sa_share_ctrl.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/sa_share_ctrl.sv
// sa_share_ctrl: round-robin front end that shares one multi-cycle arithmetic
// unit (start/done handshake) between NREQ requesters.
// Optional feature macro: SA_TIMEOUT_EN adds a WAIT watchdog that aborts a job
// after TIMEOUT cycles and returns {W{1'b1}} with err.
//
// state  | meaning
// -------+-----------------------------------------------------------
// IDLE   | no job; arbitrate from rr_ptr, latch winner operand
// ISSUE  | one-cycle unit_start pulse to the shared unit
// WAIT   | unit computing; finish on unit_done (or watchdog expiry)
// RESP   | one-cycle q_valid pulse to owner, advance rr_ptr
module sa_share_ctrl #(
  parameter int NREQ    = 4,
  parameter int W       = 8,
  parameter int TIMEOUT = 64
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [NREQ-1:0]   req,
  input  logic [NREQ*W-1:0] a_in,
  output logic [NREQ-1:0]   gnt,
  output logic [W-1:0]      q_out,
  output logic [NREQ-1:0]   q_valid,
  output logic              err,
  output logic              busy,
  output logic [W-1:0]      unit_a,
  output logic              unit_start,
  input  logic              unit_done,
  input  logic [W-1:0]      unit_q
);

  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

  if (NREQ < 2 || NREQ > 8 || TIMEOUT < 1) begin : g_bad_param
    $error("sa_share_ctrl: NREQ must be 2..8 and TIMEOUT at least 1");
  end

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_RESP} state_t;

  state_t        state, state_nxt;
  logic [PW-1:0] rr_ptr;
  logic [PW-1:0] owner;
  logic [PW-1:0] pick_idx;
  logic          pick_valid;

`ifdef SA_TIMEOUT_EN
  localparam int WDW = $clog2(TIMEOUT + 1);
  logic [WDW-1:0] watchdog;
  logic           err_r;
  logic           wd_expired;

  assign wd_expired = (watchdog == WDW'(TIMEOUT - 1));
  assign err        = (state == S_RESP) && err_r;
`else
  assign err = 1'b0;
`endif

  assign unit_start = (state == S_ISSUE);
  assign busy       = (state != S_IDLE);
  assign q_valid    = (state == S_RESP) ? gnt : '0;

  // First requesting index at or above rr_ptr, wrapping at NREQ.
  always_comb begin : pick_search
    int idx;
    pick_valid = 1'b0;
    pick_idx   = '0;
    idx        = 0;
    for (int k = 0; k < NREQ; k++) begin
      idx = int'(rr_ptr) + k;
      if (idx >= NREQ) idx = idx - NREQ;
      if (!pick_valid && req[idx]) begin
        pick_valid = 1'b1;
        pick_idx   = PW'(idx);
      end
    end
  end

  // Next-state decode; a unit_done in the expiry cycle takes priority.
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (pick_valid) state_nxt = S_ISSUE;
      S_ISSUE: state_nxt = S_WAIT;
      S_WAIT: begin
        if (unit_done) state_nxt = S_RESP;
`ifdef SA_TIMEOUT_EN
        else if (wd_expired) state_nxt = S_RESP;
`endif
      end
      S_RESP:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // State register plus grant, operand, result and pointer bookkeeping.
  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= S_IDLE;
      rr_ptr <= '0;
      owner  <= '0;
      gnt    <= '0;
      q_out  <= '0;
      unit_a <= '0;
`ifdef SA_TIMEOUT_EN
      watchdog <= '0;
      err_r    <= 1'b0;
`endif
    end else begin
      state <= state_nxt;
      case (state)
        S_IDLE: begin
          if (pick_valid) begin
            owner  <= pick_idx;
            gnt    <= NREQ'(1) << pick_idx;
            unit_a <= a_in[pick_idx*W +: W];
`ifdef SA_TIMEOUT_EN
            err_r  <= 1'b0;
`endif
          end
        end
        S_ISSUE: begin
`ifdef SA_TIMEOUT_EN
          watchdog <= '0;
`endif
        end
        S_WAIT: begin
          if (unit_done) q_out <= unit_q;
`ifdef SA_TIMEOUT_EN
          else if (wd_expired) begin
            q_out <= '1;
            err_r <= 1'b1;
          end else begin
            watchdog <= watchdog + WDW'(1);
          end
`endif
        end
        S_RESP: begin
          gnt    <= '0;
          rr_ptr <= (owner == PW'(NREQ - 1)) ? '0 : owner + PW'(1);
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_sa_share_ctrl.sv
// Bench for sa_share_ctrl: directed scenarios plus a randomized run, all
// checked against a job-level timeline model of the scheduler.
module tb_sa_share_ctrl;
  localparam int NREQ    = 4;
  localparam int W       = 8;
  localparam int TIMEOUT = 64;

  logic              clk = 1'b0;
  logic              reset;
  logic [NREQ-1:0]   req;
  logic [NREQ*W-1:0] a_in;
  logic [NREQ-1:0]   gnt;
  logic [W-1:0]      q_out;
  logic [NREQ-1:0]   q_valid;
  logic              err;
  logic              busy;
  logic [W-1:0]      unit_a;
  logic              unit_start;
  logic              unit_done;
  logic [W-1:0]      unit_q;

  always #5 clk = ~clk;

  sa_share_ctrl #(.NREQ(NREQ), .W(W), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .reset(reset), .req(req), .a_in(a_in), .gnt(gnt),
    .q_out(q_out), .q_valid(q_valid), .err(err), .busy(busy),
    .unit_a(unit_a), .unit_start(unit_start), .unit_done(unit_done),
    .unit_q(unit_q)
  );

  int n_cmp = 0;
  int n_bad = 0;
  int cyc   = 0;

  // reference model: one job at a time, described by its grant cycle
  bit          m_active = 0;
  int          m_owner, m_ptr = 0, m_tgrant = 0, m_free_from = 0;
  logic [W-1:0] m_opnd;

  // stimulus state
  bit [NREQ-1:0] hold = '0;
  int            raise_cyc[NREQ];
  int            waited[NREQ];
  int            dcnt = 0;
  logic [W-1:0]  dres;
  bit            rand_mode = 0, keep_hold = 0, force_done = 0;
  int            dly_mode = 1;
  logic [W-1:0]  a_val[NREQ];
  logic [NREQ-1:0] grants_q[$];
  int            n_start = 0;
  logic [W-1:0]  last_q;

  task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic int pick(logic [NREQ-1:0] r, int p);
    for (int k = 0; k < NREQ; k++)
      if (r[(p + k) % NREQ]) return (p + k) % NREQ;
    return 0;
  endfunction

  function automatic logic [W-1:0] unit_f(logic [W-1:0] a);
    return a * a;
  endfunction

  task automatic set_hold(logic [NREQ-1:0] m);
    for (int i = 0; i < NREQ; i++)
      if (m[i] && !hold[i]) begin
        raise_cyc[i] = cyc + 1;
        waited[i]    = 0;
      end
    hold = m;
  endtask

  // One cycle: check outputs at the falling edge, update the model, drive inputs.
  task automatic step();
    bit resp, tmo;
    resp = 0;
    tmo  = 0;
    @(negedge clk);
    cyc++;
    if (reset) begin
      m_active    = 0;
      m_ptr       = 0;
      m_free_from = cyc;
      check("rst_gnt", 32'(gnt), 0);
      check("rst_q_valid", 32'(q_valid), 0);
      check("rst_busy", 32'(busy), 0);
      check("rst_start", 32'(unit_start), 0);
      check("rst_err", 32'(err), 0);
      check("rst_q_out", 32'(q_out), 0);
      check("rst_unit_a", 32'(unit_a), 0);
    end else begin
      if (!m_active && cyc - 1 >= m_free_from && req != '0) begin
        m_active = 1;
        m_owner  = pick(req, m_ptr);
        m_opnd   = a_in[m_owner*W +: W];
        m_tgrant = cyc;
      end
      if (m_active && cyc > m_tgrant + 1 && unit_done) resp = 1;
`ifdef SA_TIMEOUT_EN
      else if (m_active && cyc == m_tgrant + 1 + TIMEOUT) begin
        resp = 1;
        tmo  = 1;
      end
`endif
      check("gnt", 32'(gnt), m_active ? (32'(1) << m_owner) : 0);
      check("busy", 32'(busy), 32'(m_active));
      check("unit_start", 32'(unit_start), 32'(m_active && cyc == m_tgrant));
      check("q_valid", 32'(q_valid), resp ? (32'(1) << m_owner) : 0);
      check("err", 32'(err), 32'(tmo));
      if (m_active) check("unit_a", 32'(unit_a), 32'(m_opnd));
      if (resp) begin
        check("q_out", 32'(q_out), tmo ? 32'({W{1'b1}}) : 32'(unit_f(m_opnd)));
        last_q = q_out;
      end
      if (m_active && cyc == m_tgrant) grants_q.push_back(gnt);
      if (unit_start) n_start++;
      if (resp) begin
        for (int i = 0; i < NREQ; i++)
          if (i != m_owner && hold[i] && raise_cyc[i] < m_tgrant) waited[i]++;
        check("fair_wait", 32'(waited[m_owner] <= NREQ - 1), 1);
        waited[m_owner] = 0;
        m_ptr       = (m_owner + 1) % NREQ;
        m_active    = 0;
        m_free_from = cyc + 1;
        if (!keep_hold) hold[m_owner] = 1'b0;
      end
    end
    // shared unit behaviour
    unit_done = 1'b0;
    unit_q    = W'($urandom);
    if (dcnt > 0) begin
      dcnt--;
      if (dcnt == 0) begin
        unit_done = 1'b1;
        unit_q    = dres;
      end
    end
    if (unit_start && !reset) begin
      dres = unit_f(unit_a);
      dcnt = (dly_mode > 0) ? dly_mode : (dly_mode == 0) ? int'($urandom_range(1, 8)) : 0;
    end
    if (force_done) begin
      unit_done  = 1'b1;
      force_done = 0;
    end
    // stray done pulses where the scheduler must ignore them
    if (rand_mode && !unit_done && ((!m_active && dcnt == 0) || (m_active && cyc == m_tgrant))
        && $urandom_range(0, 7) == 0)
      unit_done = 1'b1;
    if (rand_mode) begin
      if (m_active && hold[m_owner] && $urandom_range(0, 15) == 0) hold[m_owner] = 1'b0;
      for (int i = 0; i < NREQ; i++)
        if (!hold[i] && !(m_active && m_owner == i) && $urandom_range(0, 3) == 0) begin
          hold[i]      = 1'b1;
          raise_cyc[i] = cyc;
          waited[i]    = 0;
        end
      for (int i = 0; i < NREQ; i++) a_in[i*W +: W] = W'($urandom);
    end else begin
      for (int i = 0; i < NREQ; i++) a_in[i*W +: W] = a_val[i];
    end
    req = hold;
  endtask

  task automatic do_reset(int n);
    reset = 1'b1;
    hold  = '0;
    dcnt  = 0;
    repeat (n) step();
    reset = 1'b0;
  endtask

  initial begin
    int s0;
    reset = 1'b1; req = '0; a_in = '0; unit_done = 1'b0; unit_q = '0;
    for (int i = 0; i < NREQ; i++) begin
      a_val[i] = '0; raise_cyc[i] = 0; waited[i] = 0;
    end
    do_reset(2);
    repeat (3) step();

    // single requester, 5-cycle unit, 12*12=144
    a_val[0] = 8'd12;
    dly_mode = 5;
    s0 = n_start;
    set_hold(4'b0001);
    repeat (15) step();
    check("t2_starts", 32'(n_start - s0), 1);
    check("t2_q", 32'(last_q), 144);

    // all four held, served 0,1,2,3,0
    do_reset(1);
    keep_hold = 1;
    dly_mode  = 3;
    for (int i = 0; i < NREQ; i++) a_val[i] = W'(i + 1);
    grants_q.delete();
    set_hold(4'b1111);
    for (int t = 0; t < 200 && grants_q.size() < 5; t++) step();
    check("t3_count", 32'(grants_q.size()), 5);
    if (grants_q.size() >= 5) begin
      check("t3_g0", 32'(grants_q[0]), 32'h1);
      check("t3_g1", 32'(grants_q[1]), 32'h2);
      check("t3_g2", 32'(grants_q[2]), 32'h4);
      check("t3_g3", 32'(grants_q[3]), 32'h8);
      check("t3_g4", 32'(grants_q[4]), 32'h1);
    end
    keep_hold = 0;

    // pointer at 2 then req 0011 wraps to requester 0
    do_reset(1);
    set_hold(4'b0010);
    for (int t = 0; t < 50 && !(m_ptr == 2 && !m_active); t++) step();
    grants_q.delete();
    set_hold(4'b0011);
    for (int t = 0; t < 100 && grants_q.size() < 2; t++) step();
    check("t4_count", 32'(grants_q.size()), 2);
    if (grants_q.size() >= 2) begin
      check("t4_g0", 32'(grants_q[0]), 32'h1);
      check("t4_g1", 32'(grants_q[1]), 32'h2);
    end

    // reset while waiting, then a late done must be ignored
    do_reset(1);
    dly_mode = -1;
    set_hold(4'b0001);
    for (int t = 0; t < 20 && !(m_active && cyc >= m_tgrant + 3); t++) step();
    s0 = n_start;
    do_reset(1);
    force_done = 1;
    repeat (6) step();
    check("t5_no_restart", 32'(n_start - s0), 0);
    check("t5_idle", 32'(busy), 0);

    // unit never completes
    set_hold(4'b0001);
    repeat (100) step();
`ifdef SA_TIMEOUT_EN
    check("t6_recovered", 32'(m_active), 0);
`else
    check("t6_hang_busy", 32'(busy), 1);
`endif

    // randomized traffic
    do_reset(1);
    rand_mode = 1;
    dly_mode  = 0;
    repeat (3000) step();
    rand_mode = 0;
    hold = '0;
    repeat (20) step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
